fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the MIPS core. It sits between the `PC` register and the ID stage: it reads `PC.out`, fetches the instruction over a req/ack instruction-memory port, and presents it to ID through an IF/ID register with stall and flush. `PC` has no enable and loads `new_pc` on every rising edge. This block therefore drives `PC.new_pc` every cycle: it holds the current value, advances by 4, or redirects to a branch target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: address of the first fetched instruction.
- `clock` in 1: rising-edge clock shared with `PC`.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc` in 32: current PC, from `PC.out`.
- `new_pc` out 32: next PC, to `PC.new_pc`; combinational.
- `imem_req` out 1: fetch request; registered.
- `imem_addr` out 32: fetch address; registered, stable while `imem_req` is high.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: ID cannot accept; IF/ID register holds its contents.
- `branch_taken` in 1: one-cycle redirect pulse from ID/EX.
- `branch_target` in 32: redirect address, valid with `branch_taken`.
- `if_valid` out 1: IF/ID register holds a live instruction.
- `if_instr` out 32: instruction in the IF/ID register.
- `if_pc4` out 32: fetch address + 4 of `if_instr`.

## Operation
- Reset (`reset_n`=0):
  - state=IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0 (NOP), `if_pc4`=0, held-instruction buffer cleared.
  - `new_pc`=`RESET_PC`, overriding all other logic, so `PC` loads `RESET_PC`.
  - Reset must span at least one rising edge.
- `new_pc` defaults to `pc` (hold). Overrides, listed highest priority first:
  - `branch_taken`=1: `new_pc`=`branch_target`.
  - BUSY & `imem_ack` (no branch): `new_pc`=`pc+4`. Arithmetic is 32-bit modulo, so `32'hFFFF_FFFC`+4 wraps to 0.
- ID handshake:
  - ID consumes the IF/ID contents on an edge where `if_valid`=1 and `stall`=0.
  - `can_load` = `!if_valid || !stall`.
- FSM states, transitions evaluated at each rising edge:
  - IDLE, `branch_taken`: stay IDLE, no request.
  - IDLE, otherwise: `imem_req`<=1, `imem_addr`<=`pc`, go to BUSY.
  - BUSY, no `imem_ack`, no `branch_taken`: hold `imem_req` and `imem_addr`.
  - BUSY, `imem_ack` & `branch_taken`: discard `imem_rdata`, `imem_req`<=0, go to IDLE.
  - BUSY, `branch_taken`, no `imem_ack`: go to DRAIN; the request stays up with the same address.
  - BUSY, `imem_ack` & `can_load`: `if_instr`<=`imem_rdata`, `if_pc4`<=`imem_addr+4`, `if_valid`<=1, `imem_req`<=0, go to IDLE.
  - BUSY, `imem_ack` & !`can_load`: capture `imem_rdata` and `imem_addr+4` into the held buffer, `imem_req`<=0, go to HELD.
  - DRAIN, `imem_ack`: discard data, `imem_req`<=0, go to IDLE. A second `branch_taken` in DRAIN updates `new_pc` only.
  - HELD, `branch_taken`: discard the buffer, go to IDLE.
  - HELD, `can_load`: move the buffer into IF/ID, `if_valid`<=1, go to IDLE.
- IF/ID flush:
  - `branch_taken` forces `if_valid`<=0 at the next edge in every state, overriding `stall`.
  - `if_instr` and `if_pc4` keep stale values; consumers qualify them with `if_valid`.
- `if_valid`<=0 on an edge where ID consumes and nothing new loads.
- At most one request is outstanding. An `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Issue latency: `pc` sampled in IDLE; `imem_req` rises after the next edge.
- Zero-wait memory (`imem_ack` in the first BUSY cycle): `if_valid` rises 2 edges after the IDLE cycle.
- `PC` advances on the same edge that loads IF/ID.
- Throughput: 1 instruction per 2 cycles with zero-wait memory; each extra wait state adds 1 cycle.
- Branch: `PC` holds `branch_target` one edge after the pulse; the first request to it issues from IDLE once `pc` = target.
- Reset asserted mid-request: all outputs go to reset values immediately. Instruction memory is reset from the same `reset_n`.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory, no stall: `imem_addr` sequence 0x100, 0x104, 0x108; `if_instr` matches memory; `if_pc4`=0x104, 0x108, 0x10C.
- 3 wait states at `pc`=0x10: `imem_req` and `imem_addr`=0x10 stable for 4 cycles; `new_pc`=0x10 until the ack cycle, then 0x14.
- `if_valid`=1, `stall` held 5 cycles while ack 0x8C000000 arrives: FSM enters HELD, IF/ID unchanged; on stall release `if_instr`=0x8C000000 next edge.
- `branch_taken`, target 0x200, during BUSY with ack 2 cycles later: `if_valid`=0 next edge, DRAIN, data discarded, next `imem_addr`=0x200.
- `branch_taken` coincident with `imem_ack` and `stall`=1: data dropped, `if_valid`=0, `new_pc`=target in that cycle.
- `reset_n` pulsed low mid-BUSY: `imem_req`=0 and `if_valid`=0 asynchronously; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack port between the fetch stage and instruction memory.
// One request is outstanding at a time; imem_rdata is valid in the imem_ack cycle.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: drives the PC's next value, fetches over a req/ack
// memory port and presents the instruction to ID through a stallable, flushable IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        pc,
    output logic [31:0]        new_pc,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc4
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_HELD  = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic        req_q,        req_d;
    logic [31:0] addr_q,       addr_d;
    logic        valid_q,      valid_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pc4_q,        pc4_d;
    logic [31:0] held_instr_q, held_instr_d;
    logic [31:0] held_pc4_q,   held_pc4_d;
    logic        can_load_s;
    logic [31:0] new_pc_s;

    // Next-PC select; reset forces RESET_PC so the free-running PC register starts there.
    always_comb begin
        new_pc_s = pc;
        if (!reset_n) begin
            new_pc_s = RESET_PC;
        end else if (branch_taken) begin
            new_pc_s = branch_target;
        end else if ((state_q == S_BUSY) && imem.imem_ack) begin
            new_pc_s = pc + 32'd4;
        end else begin
            new_pc_s = pc;
        end
    end

    // Fetch FSM next state plus IF/ID register and held-buffer next values.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        held_instr_d = held_instr_q;
        held_pc4_d   = held_pc4_q;
        can_load_s   = !valid_q || !stall;
        // ID consuming without a new load empties the IF/ID register.
        valid_d      = (valid_q && !stall) ? 1'b0 : valid_q;

        case (state_q)
            S_IDLE: begin
                if (!branch_taken) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (imem.imem_ack) begin
                    req_d = 1'b0;
                    if (branch_taken) begin
                        state_d = S_IDLE;
                    end else if (can_load_s) begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = addr_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        held_instr_d = imem.imem_rdata;
                        held_pc4_d   = addr_q + 32'd4;
                        state_d      = S_HELD;
                    end
                end else if (branch_taken) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DRAIN: begin
                if (imem.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_HELD: begin
                if (branch_taken) begin
                    state_d = S_IDLE;
                end else if (can_load_s) begin
                    instr_d = held_instr_q;
                    pc4_d   = held_pc4_q;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HELD;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A redirect flushes IF/ID regardless of stall; stale payload stays.
        if (branch_taken) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            pc4_q        <= 32'h0000_0000;
            held_instr_q <= 32'h0000_0000;
            held_pc4_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            held_instr_q <= held_instr_d;
            held_pc4_q   <= held_pc4_d;
        end
    end

    assign new_pc         = new_pc_s;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_valid       = valid_q;
    assign if_instr       = instr_q;
    assign if_pc4         = pc4_q;

endmodule
